stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: MAX_MIN, default 59, highest minute value reached before saturation (range 0..99).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: tick_1hz  input  1  single-cycle enable pulse once per second, synchronous to clk.
REQ-005 Port: scan_sel  input  2  display digit scan select from the divider; 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
REQ-006 Port: btn_start  input  1  single-cycle pulse (already debounced/one-pulsed); start/pause toggle.
REQ-007 Port: btn_clear  input  1  single-cycle pulse (already debounced/one-pulsed); clear request.
REQ-008 Port: digit_an  output  4  active-low digit enable, one-hot-low per scan_sel.
REQ-009 Port: digit_bcd  output  4  BCD value of the currently scanned digit.
REQ-010 Port: running  output  1  high while in RUN.
REQ-011 Port: done  output  1  high while in DONE.

Function
REQ-012 FSM states SHALL be IDLE, RUN, PAUSE, DONE, with IDLE entered on reset.
REQ-013 Time SHALL be held as four BCD digits: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-9.
REQ-014 IDLE: btn_start -> RUN; btn_clear -> stay IDLE with digits forced 00:00; tick_1hz ignored.
REQ-015 RUN: each tick_1hz SHALL increment time by one second in the same clock edge it is sampled.
REQ-016 Increment carry chain: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to minutes; min_ones 9->0 carries to min_tens.
REQ-017 RUN: btn_start -> PAUSE; btn_clear ignored.
REQ-018 RUN: a tick arriving with time == MAX_MIN:59 SHALL leave time at MAX_MIN:59 and move to DONE (saturate, no wrap).
REQ-019 RUN: tick_1hz and btn_start in the same cycle -> tick counted, then state PAUSE (or DONE if REQ-018 applies; DONE wins).
REQ-020 PAUSE: time held; tick ignored; btn_start -> RUN; btn_clear -> IDLE with time 00:00.
REQ-021 DONE: time held; btn_start and tick ignored; btn_clear -> IDLE with time 00:00.
REQ-022 PAUSE: btn_start and btn_clear in the same cycle -> btn_clear wins (IDLE, 00:00).
REQ-023 IDLE: btn_start and btn_clear in the same cycle -> RUN with time 00:00; a tick in that same cycle is not counted.
REQ-024 digit_an and digit_bcd SHALL be registered, reflecting scan_sel and digit values sampled one clock earlier (latency 1).
REQ-025 digit_an mapping: scan_sel 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
REQ-026 running and done SHALL be registered decodes of the FSM state, updating on the same edge as the state change.

Reset
REQ-027 On rst_n low, asynchronously: state IDLE, all digits 0, digit_an 4'b1111, digit_bcd 4'h0, running 0, done 0.
REQ-028 Reset asserted mid-RUN SHALL abort counting immediately; after release the block stays in IDLE until btn_start.
REQ-029 The first clock edge after rst_n release SHALL perform normal operation (no extra wait cycles).

Verification
REQ-030 Reset, btn_start, 75 ticks -> running=1, time 01:15; scan_sel 0..3 -> digit_bcd 5,1,1,0 one cycle later with digit_an 1110/1101/1011/0111.
REQ-031 Run to 00:09, tick -> 00:10; run to 00:59, tick -> 01:00; run to 09:59, tick -> 10:00.
REQ-032 MAX_MIN=1: run to 01:59, tick -> done=1, running=0, time 01:59; further ticks and btn_start -> unchanged; btn_clear -> IDLE, 00:00.
REQ-033 In RUN at 00:05, assert tick_1hz and btn_start in the same cycle -> time 00:06, state PAUSE; 3 ticks -> still 00:06; btn_clear in RUN ignored (check before pause).
REQ-034 In PAUSE, btn_start and btn_clear in the same cycle -> IDLE, 00:00; in IDLE, btn_start plus tick in the same cycle -> RUN, time 00:00.
REQ-035 Assert rst_n low between clock edges during RUN at 00:30 -> outputs reach reset values without a clock edge; after release, ticks leave time at 00:00.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   MM:SS stopwatch controller with a start/pause/clear FSM and a registered
//   multiplexed 4-digit BCD display output. The count saturates at
//   MAX_MIN:59, where the FSM parks in DONE until it is cleared.
//
// Parameters
//   MAX_MIN    highest minute value reached before saturation (0..99)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tick_1hz   one-cycle enable pulse, once per second
//   scan_sel   digit select: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens
//   btn_start  one-cycle start/pause toggle pulse
//   btn_clear  one-cycle clear request pulse
//   digit_an   active-low digit enable for the scanned digit (registered)
//   digit_bcd  BCD value of the scanned digit (registered)
//   running    high while in RUN (registered)
//   done       high while in DONE (registered)
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [1:0] scan_sel,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] digit_an,
    output logic [3:0] digit_bcd,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 32'd10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 32'd10);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] sec_ones_r;
    logic [3:0] sec_tens_r;
    logic [3:0] min_ones_r;
    logic [3:0] min_tens_r;
    logic [3:0] inc_sec_ones_s;
    logic [3:0] inc_sec_tens_s;
    logic [3:0] inc_min_ones_s;
    logic [3:0] inc_min_tens_s;
    logic       at_max_s;
    logic       load_zero_s;
    logic       load_inc_s;
    logic [3:0] an_s;
    logic [3:0] bcd_s;
    logic [3:0] digit_an_r;
    logic [3:0] digit_bcd_r;
    logic       running_r;
    logic       done_r;

    // Saturation point: time currently reads MAX_MIN:59.
    assign at_max_s = (min_tens_r == MAX_TENS) && (min_ones_r == MAX_ONES) &&
                      (sec_tens_r == 4'd5) && (sec_ones_r == 4'd9);

    // Time plus one second, BCD carry chain across the four digits.
    always_comb begin
        inc_sec_ones_s = sec_ones_r + 4'd1;
        inc_sec_tens_s = sec_tens_r;
        inc_min_ones_s = min_ones_r;
        inc_min_tens_s = min_tens_r;
        if (sec_ones_r == 4'd9) begin
            inc_sec_ones_s = 4'd0;
            if (sec_tens_r == 4'd5) begin
                inc_sec_tens_s = 4'd0;
                if (min_ones_r == 4'd9) begin
                    inc_min_ones_s = 4'd0;
                    inc_min_tens_s = min_tens_r + 4'd1;
                end else begin
                    inc_min_ones_s = min_ones_r + 4'd1;
                end
            end else begin
                inc_sec_tens_s = sec_tens_r + 4'd1;
            end
        end else begin
            inc_sec_ones_s = sec_ones_r + 4'd1;
        end
    end

    // FSM next state and time-update controls.
    always_comb begin
        next_state_s = state_r;
        load_zero_s  = 1'b0;
        load_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // Clear still zeroes time even when start moves us to RUN;
                // ticks are never counted here.
                if (btn_start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
                if (btn_clear) begin
                    load_zero_s = 1'b1;
                end else begin
                    load_zero_s = 1'b0;
                end
            end
            RUN: begin
                // The tick is counted on the same edge as a pause request;
                // hitting the saturation point overrides the pause.
                if (tick_1hz) begin
                    if (at_max_s) begin
                        next_state_s = DONE;
                    end else begin
                        load_inc_s = 1'b1;
                        if (btn_start) begin
                            next_state_s = PAUSE;
                        end else begin
                            next_state_s = RUN;
                        end
                    end
                end else if (btn_start) begin
                    next_state_s = PAUSE;
                end else begin
                    next_state_s = RUN;
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    next_state_s = IDLE;
                    load_zero_s  = 1'b1;
                end else if (btn_start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = PAUSE;
                end
            end
            DONE: begin
                if (btn_clear) begin
                    next_state_s = IDLE;
                    load_zero_s  = 1'b1;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
                load_zero_s  = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Time digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            min_ones_r <= 4'd0;
            min_tens_r <= 4'd0;
        end else if (load_zero_s) begin
            sec_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            min_ones_r <= 4'd0;
            min_tens_r <= 4'd0;
        end else if (load_inc_s) begin
            sec_ones_r <= inc_sec_ones_s;
            sec_tens_r <= inc_sec_tens_s;
            min_ones_r <= inc_min_ones_s;
            min_tens_r <= inc_min_tens_s;
        end else begin
            sec_ones_r <= sec_ones_r;
            sec_tens_r <= sec_tens_r;
            min_ones_r <= min_ones_r;
            min_tens_r <= min_tens_r;
        end
    end

    // Display digit select decode from the current scan position.
    always_comb begin
        an_s  = 4'b1111;
        bcd_s = 4'h0;
        case (scan_sel)
            2'd0: begin
                an_s  = 4'b1110;
                bcd_s = sec_ones_r;
            end
            2'd1: begin
                an_s  = 4'b1101;
                bcd_s = sec_tens_r;
            end
            2'd2: begin
                an_s  = 4'b1011;
                bcd_s = min_ones_r;
            end
            2'd3: begin
                an_s  = 4'b0111;
                bcd_s = min_tens_r;
            end
            default: begin
                an_s  = 4'b1111;
                bcd_s = 4'h0;
            end
        endcase
    end

    // Registered outputs; status flags decode the state being entered so
    // they change on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_an_r  <= 4'b1111;
            digit_bcd_r <= 4'h0;
            running_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            digit_an_r  <= an_s;
            digit_bcd_r <= bcd_s;
            running_r   <= (next_state_s == RUN);
            done_r      <= (next_state_s == DONE);
        end
    end

    assign digit_an  = digit_an_r;
    assign digit_bcd = digit_bcd_r;
    assign running   = running_r;
    assign done      = done_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Two instances: the default MAX_MIN=59 and a MAX_MIN=1 copy, sharing
//   stimulus. A reference model keeps elapsed time as a plain second count
//   per instance; every cycle the outputs of both are compared with it, and
//   directed scenarios additionally compare against hand-written times.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic [1:0] scan_sel = 2'd0;
    logic [3:0] an0, bcd0, an1, bcd1;
    logic       run0, done0, run1, done1;

    int n_vec = 0;
    int n_err = 0;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int m_mode [2];
    int m_secs [2];
    int max_secs [2];

    always #5 clk = ~clk;

    stopwatch_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .scan_sel(scan_sel),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .digit_an(an0), .digit_bcd(bcd0), .running(run0), .done(done0)
    );

    stopwatch_ctrl #(.MAX_MIN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .scan_sel(scan_sel),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .digit_an(an1), .digit_bcd(bcd1), .running(run1), .done(done1)
    );

    function automatic logic [3:0] digit_of(int secs, int sel);
        int s;
        int m;
        s = secs % 60;
        m = secs / 60;
        case (sel)
            0:       return 4'(s % 10);
            1:       return 4'(s / 10);
            2:       return 4'(m % 10);
            default: return 4'(m / 10);
        endcase
    endfunction

    function automatic logic [3:0] an_of(int sel);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << sel);
    endfunction

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE;
            m_secs[d] = 0;
        end
    endtask

    task automatic model_step(int d, bit t, bit s, bit c);
        case (m_mode[d])
            M_IDLE: begin
                if (s) m_mode[d] = M_RUN;
                m_secs[d] = 0;
            end
            M_RUN: begin
                if (t && m_secs[d] == max_secs[d]) begin
                    m_mode[d] = M_DONE;
                end else begin
                    if (t) m_secs[d] = m_secs[d] + 1;
                    if (s) m_mode[d] = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (c) begin
                    m_mode[d] = M_IDLE;
                    m_secs[d] = 0;
                end else if (s) begin
                    m_mode[d] = M_RUN;
                end
            end
            default: begin
                if (c) begin
                    m_mode[d] = M_IDLE;
                    m_secs[d] = 0;
                end
            end
        endcase
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit after
    // the rising edge, return at the next falling edge.
    task automatic step(bit t, bit s, bit c, logic [1:0] sel);
        logic [3:0] eb0, eb1, ea;
        tick_1hz  = t;
        btn_start = s;
        btn_clear = c;
        scan_sel  = sel;
        eb0 = digit_of(m_secs[0], int'(sel));
        eb1 = digit_of(m_secs[1], int'(sel));
        ea  = an_of(int'(sel));
        @(posedge clk);
        model_step(0, t, s, c);
        model_step(1, t, s, c);
        #1;
        chk("an0",   an0,  ea);
        chk("bcd0",  bcd0, eb0);
        chk("run0",  {3'b000, run0},  4'(m_mode[0] == M_RUN));
        chk("done0", {3'b000, done0}, 4'(m_mode[0] == M_DONE));
        chk("an1",   an1,  ea);
        chk("bcd1",  bcd1, eb1);
        chk("run1",  {3'b000, run1},  4'(m_mode[1] == M_RUN));
        chk("done1", {3'b000, done1}, 4'(m_mode[1] == M_DONE));
        @(negedge clk);
        tick_1hz  = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
    endtask

    // Scan all four digits of one instance against a hand-written MM:SS.
    task automatic check_time(int d, int mm, int ss, string tag);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 2'(k));
            chk(tag, (d == 0) ? bcd0 : bcd1, digit_of(mm * 60 + ss, k));
        end
    endtask

    task automatic check_reset_outs(string tag);
        chk({tag, "_an"},   an0, 4'b1111);
        chk({tag, "_bcd"},  bcd0, 4'h0);
        chk({tag, "_run"},  {3'b000, run0}, 4'h0);
        chk({tag, "_done"}, {3'b000, done0}, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        max_secs[0] = 59 * 60 + 59;
        max_secs[1] = 1 * 60 + 59;
        model_reset();

        // Start, 75 seconds, scan readout.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 2'd0);
        ticks(75);
        chk("run_75", {3'b000, run0}, 4'h1);
        check_time(0, 1, 15, "t_0115");

        // Carry boundaries; MAX_MIN=1 instance saturates along the way.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 2'd0);
        ticks(9);   check_time(0, 0, 9,  "t_0009");
        ticks(1);   check_time(0, 0, 10, "t_0010");
        ticks(49);  check_time(0, 0, 59, "t_0059");
        ticks(1);   check_time(0, 1, 0,  "t_0100");
        ticks(539); check_time(0, 9, 59, "t_0959");
        ticks(1);   check_time(0, 10, 0, "t_1000");

        // Saturated instance: held at 01:59 through ticks and start.
        chk("sat_done", {3'b000, done1}, 4'h1);
        chk("sat_run",  {3'b000, run1},  4'h0);
        check_time(1, 1, 59, "sat_0159");
        ticks(3);
        step(1'b0, 1'b1, 1'b0, 2'd0);
        check_time(1, 1, 59, "sat_hold");
        chk("sat_done2", {3'b000, done1}, 4'h1);
        step(1'b0, 1'b0, 1'b1, 2'd0);
        chk("sat_clr", {3'b000, done1}, 4'h0);
        check_time(1, 0, 0, "sat_0000");

        // Clear ignored in RUN; tick+start counts then pauses.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 2'd0);
        ticks(5);
        step(1'b0, 1'b0, 1'b1, 2'd0);
        chk("clr_ign", {3'b000, run0}, 4'h1);
        check_time(0, 0, 5, "t_0005");
        step(1'b1, 1'b1, 1'b0, 2'd0);
        chk("tp_run", {3'b000, run0}, 4'h0);
        check_time(0, 0, 6, "t_0006");
        ticks(3);
        check_time(0, 0, 6, "pause_hold");

        // Start+clear in PAUSE; start+tick in IDLE.
        step(1'b0, 1'b1, 1'b1, 2'd0);
        chk("pc_run", {3'b000, run0}, 4'h0);
        check_time(0, 0, 0, "pc_0000");
        step(1'b1, 1'b1, 1'b0, 2'd0);
        chk("it_run", {3'b000, run0}, 4'h1);
        check_time(0, 0, 0, "it_0000");
        do_reset();
        step(1'b1, 1'b1, 1'b1, 2'd0);
        chk("itc_run", {3'b000, run0}, 4'h1);
        check_time(0, 0, 0, "itc_0000");

        // Asynchronous reset mid-RUN at 00:30.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 2'd0);
        ticks(30);
        check_time(0, 0, 30, "t_0030");
        step(1'b0, 1'b0, 1'b0, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(5);
        chk("post_rst_run", {3'b000, run0}, 4'h0);
        check_time(0, 0, 0, "post_rst");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, ($urandom % 20) == 0,
                 ($urandom % 40) == 0, 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
